// File: rtl/step_pulse_gen_if.sv
// Pushbutton/switch inputs and step-pulse outputs of the step pulse generator.
// The generator sits on the slave side; the board or bench drives the master side.
interface step_pulse_gen_if;
  logic       btn_raw;
  logic       sw_raw;
  logic       step;
  logic       w_out;
  logic [7:0] step_count;
  logic [1:0] state;

  modport master (
    output btn_raw, sw_raw,
    input  step, w_out, step_count, state
  );

  modport slave (
    input  btn_raw, sw_raw,
    output step, w_out, step_count, state
  );
endinterface

// File: rtl/step_pulse_gen.sv
// Debounced single-step generator: one clock-enable pulse per accepted button press,
// capturing the slide switch value and counting presses.
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic            clk,
  input logic            reset,
  step_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    PRESS_CNT   = 2'b01,
    PRESSED     = 2'b10,
    RELEASE_CNT = 2'b11
  } state_t;

  // The sample that leaves IDLE/PRESSED is the first of the DEBOUNCE_CYCLES
  // stable samples, so the counter terminates one short of DEBOUNCE_CYCLES-1.
  localparam logic [19:0] LAST = 20'(DEBOUNCE_CYCLES - 2);

  logic [1:0]  btn_sync, sw_sync;
  logic        btn_s, sw_s;
  state_t      state_q;
  logic [19:0] cnt;
  logic        step_q;
  logic        w_q;
  logic [7:0]  count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync <= '0;
      sw_sync  <= '0;
    end else begin
      btn_sync <= {btn_sync[0], bus.btn_raw};
      sw_sync  <= {sw_sync[0],  bus.sw_raw};
    end
  end

  assign btn_s = btn_sync[1];
  assign sw_s  = sw_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt     <= '0;
      step_q  <= 1'b0;
      w_q     <= 1'b0;
      count_q <= '0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q <= PRESS_CNT;
            cnt     <= '0;
          end
        end
        PRESS_CNT: begin
          if (!btn_s) begin
            state_q <= IDLE;
          end else if (cnt == LAST) begin
            state_q <= PRESSED;
            step_q  <= 1'b1;
            w_q     <= sw_s;
            count_q <= count_q + 8'd1;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        PRESSED: begin
          // Held button parks here: no auto-repeat.
          if (!btn_s) begin
            state_q <= RELEASE_CNT;
            cnt     <= '0;
          end
        end
        RELEASE_CNT: begin
          if (btn_s) begin
            state_q <= PRESSED;
          end else if (cnt == LAST) begin
            state_q <= IDLE;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.step       = step_q;
  assign bus.w_out      = w_q;
  assign bus.step_count = count_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with DEBOUNCE_CYCLES=4 (step lands on the
// 6th edge counting the first edge that samples the button high).
module tb_step_pulse_gen;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;
  int   step_seen = 0;
  int   s0;

  step_pulse_gen_if bus();

  step_pulse_gen #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.step === 1'b1) step_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n edges; step must be high only after edge number 'at' (0 = never).
  task automatic expect_step(input string tag, input int n, input int at);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk(tag, 32'(bus.step), 32'(i == at));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_step"},  32'(bus.step),       32'd0);
    chk({tag, "_w"},     32'(bus.w_out),      32'd0);
    chk({tag, "_cnt"},   32'(bus.step_count), 32'd0);
    chk({tag, "_state"}, 32'(bus.state),      32'd0);
  endtask

  logic [11:0] rel_pat;
  logic [1:0]  rel_state [12];

  initial begin
    rel_pat = 12'b0000_0000_0100; // bit i drives edge i+1: low, low, high, then low
    rel_state = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11,
                  2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};

    reset = 1'b1;
    bus.btn_raw = 1'b0;
    bus.sw_raw  = 1'b0;
    tick(3);
    chk_zero("reset");
    reset = 1'b0;

    // Clean press, held 20 cycles
    s0 = step_seen;
    bus.sw_raw  = 1'b1;
    bus.btn_raw = 1'b1;
    expect_step("clean_step", 20, 6);
    chk("clean_w",      32'(bus.w_out),      32'd1);
    chk("clean_cnt",    32'(bus.step_count), 32'd1);
    chk("clean_state",  32'(bus.state),      32'd2);
    chk("clean_pulses", 32'(step_seen - s0), 32'd1);
    bus.btn_raw = 1'b0;
    tick(8);
    chk("clean_idle", 32'(bus.state), 32'd0);

    // Bounce rejection: 3 high, 1 low, then 10 high
    s0 = step_seen;
    bus.btn_raw = 1'b1;
    tick(3);
    bus.btn_raw = 1'b0;
    tick(1);
    bus.btn_raw = 1'b1;
    expect_step("bounce_step", 10, 6);
    chk("bounce_cnt",    32'(bus.step_count), 32'd2);
    chk("bounce_pulses", 32'(step_seen - s0), 32'd1);

    // Release bounce while PRESSED
    s0 = step_seen;
    for (int i = 0; i < 12; i++) begin
      bus.btn_raw = rel_pat[i];
      tick();
      chk($sformatf("rel_state%0d", i), 32'(bus.state), 32'(rel_state[i]));
      chk($sformatf("rel_step%0d", i),  32'(bus.step),  32'd0);
    end
    chk("rel_cnt",    32'(bus.step_count), 32'd2);
    chk("rel_pulses", 32'(step_seen - s0), 32'd0);

    // Switch isolation
    bus.sw_raw  = 1'b0;
    bus.btn_raw = 1'b1;
    expect_step("sw0_step", 8, 6);
    chk("sw0_w",   32'(bus.w_out),      32'd0);
    chk("sw0_cnt", 32'(bus.step_count), 32'd3);
    bus.sw_raw = 1'b1;
    tick(4);
    chk("sw_held_w", 32'(bus.w_out), 32'd0);
    bus.btn_raw = 1'b0;
    tick(3);
    bus.sw_raw = 1'b0;
    tick(3);
    bus.sw_raw = 1'b1;
    tick(4);
    chk("sw_idle_w",     32'(bus.w_out), 32'd0);
    chk("sw_idle_state", 32'(bus.state), 32'd0);
    bus.btn_raw = 1'b1;
    expect_step("sw1_step", 8, 6);
    chk("sw1_w",   32'(bus.w_out),      32'd1);
    chk("sw1_cnt", 32'(bus.step_count), 32'd4);
    bus.btn_raw = 1'b0;
    tick(8);

    // Reset in PRESS_CNT on the edge that would fire, button held through release
    bus.sw_raw  = 1'b1;
    bus.btn_raw = 1'b1;
    tick(5);
    chk("mid_state", 32'(bus.state), 32'd1);
    reset = 1'b1;
    tick();
    chk_zero("rst1");
    tick();
    chk_zero("rst2");
    reset = 1'b0;
    expect_step("rst_rel_step", 8, 6);
    chk("rst_rel_cnt", 32'(bus.step_count), 32'd1);
    chk("rst_rel_w",   32'(bus.w_out),      32'd1);
    bus.btn_raw = 1'b0;
    tick(8);

    // 256 presses from reset: count wraps to 0
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    s0 = step_seen;
    for (int p = 1; p <= 256; p++) begin
      bus.btn_raw = 1'b1;
      tick(8);
      bus.btn_raw = 1'b0;
      tick(8);
      if (p == 255) chk("wrap_255", 32'(bus.step_count), 32'd255);
    end
    chk("wrap_256",    32'(bus.step_count), 32'd0);
    chk("wrap_pulses", 32'(step_seen - s0), 32'd256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
